// File: rtl/clock_rate_scheduler_if.sv
// Request/select bus between requesters, the divider feedback and the scheduler.
interface clock_rate_scheduler_if #(
  parameter int unsigned N = 4
);
  logic [2:0]   req;
  logic [N-1:0] req_x0;
  logic [N-1:0] req_x1;
  logic [N-1:0] req_x2;
  logic         div_clk_in;
  logic [N-1:0] x_out;
  logic [2:0]   grant;
  logic         settled;
  logic         timeout_flag;

  // Requesters and divider side
  modport master (
    output req, req_x0, req_x1, req_x2, div_clk_in,
    input  x_out, grant, settled, timeout_flag
  );

  // Scheduler side
  modport slave (
    input  req, req_x0, req_x1, req_x2, div_clk_in,
    output x_out, grant, settled, timeout_flag
  );
endinterface

// File: rtl/clock_rate_scheduler.sv
// Priority-arbitrated divider select that ramps x_out one step per divider edge,
// with a watchdog that forces a step when the divider stalls.
module clock_rate_scheduler #(
  parameter int unsigned N      = 4,
  parameter int unsigned IDLE_X = 0,
  parameter int unsigned TMO    = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  clock_rate_scheduler_if.slave bus
);

  localparam int unsigned WD_W     = 8;
  localparam logic [N-1:0] IDLE_VAL = N'(IDLE_X);
  // Expiry fires on the TMO-th RAMP cycle without a step
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TMO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      x_q, x_d;
  logic [N-1:0]      target_c;
  logic [2:0]        grant_q, grant_d;
  logic              div_q;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              tmo_q, tmo_d;
  logic              edge_c;
  logic              expire_c;

  // Lowest-index active requester wins; no requester selects the idle value
  always_comb begin
    target_c = IDLE_VAL;
    grant_d  = 3'b000;
    if (bus.req[0]) begin
      target_c = bus.req_x0;
      grant_d  = 3'b001;
    end else if (bus.req[1]) begin
      target_c = bus.req_x1;
      grant_d  = 3'b010;
    end else if (bus.req[2]) begin
      target_c = bus.req_x2;
      grant_d  = 3'b100;
    end
  end

  assign edge_c   = bus.div_clk_in & ~div_q;
  assign expire_c = (wd_q == WD_LIM);

  // Next-state: single-step ramp toward the live target, watchdog-forced steps
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (target_c != x_q) state_d = RAMP;
      end
      RAMP: begin
        if (target_c == x_q) begin
          state_d = IDLE;
          wd_d    = '0;
        end else if (edge_c || expire_c) begin
          x_d  = (target_c > x_q) ? x_q + N'(1) : x_q - N'(1);
          wd_d = '0;
          if (!edge_c) tmo_d = 1'b1;
          if (x_d == target_c) state_d = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wd_d    = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= IDLE_VAL;
      grant_q <= 3'b000;
      div_q   <= 1'b0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      grant_q <= grant_d;
      div_q   <= bus.div_clk_in;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.x_out        = x_q;
  assign bus.grant        = grant_q;
  assign bus.settled      = (state_q == IDLE);
  assign bus.timeout_flag = tmo_q;

endmodule

// File: doc/clock_rate_scheduler.md
CLOCK_RATE_SCHEDULER -- requirements
Module: clock_rate_scheduler

Interface
REQ-001 Parameter N, default 4: width of divider select value x.
REQ-002 Parameter IDLE_X, default 0: select value applied when no requester is active.
REQ-003 Parameter TMO, default 255: watchdog limit in clk cycles without a divider edge; range 1..255.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 req  input  3  request lines; bit 0 has the highest priority, bit 2 the lowest.
REQ-007 req_x0, req_x1, req_x2  input  N each  requested divider select for requester 0, 1 and 2.
REQ-008 div_clk_in  input  1  feedback from the divider clk_out, synchronous to clk.
REQ-009 x_out  output  N  registered select value driven to the divider x input.
REQ-010 grant  output  3  registered one-hot winning requester; 000 when none.
REQ-011 settled  output  1  high when state is IDLE (x_out equals target).
REQ-012 timeout_flag  output  1  sticky watchdog-expired indicator.

Function
REQ-013 The target SHALL be req_xK of the lowest-index asserted req bit K, or IDLE_X when req is 000; the target is combinational from the current inputs.
REQ-014 grant SHALL register the one-hot of K each cycle (000 when req is 000), with one cycle of latency.
REQ-015 A register div_q SHALL sample div_clk_in every cycle; edge = div_clk_in AND NOT div_q.
REQ-016 The FSM SHALL have the states IDLE and RAMP; settled = (state == IDLE).
REQ-017 IDLE goes to RAMP on the cycle where target differs from x_out; x_out holds.
REQ-018 In RAMP, on each edge x_out SHALL step by exactly 1 toward the target, registered on that clock.
REQ-019 Step direction SHALL be re-evaluated at every step against the current target; a mid-ramp target change redirects the ramp without any jump.
REQ-020 RAMP goes to IDLE on the cycle where x_out equals target, with no edge required; this also applies when the target moves back to the current x_out.
REQ-021 x_out SHALL change only through a single-step update; it never wraps. Arithmetic is unsigned N-bit, and values stay within 0..2^N-1 because steps only approach the target.
REQ-022 A watchdog counter (8 bits) SHALL count clk cycles in RAMP since the last step; it clears on every step and on entry to RAMP.
REQ-023 When the watchdog reaches TMO without an edge, the block SHALL perform one step as if an edge occurred, clear the counter, and set timeout_flag.
REQ-024 The counter SHALL hold at 0 while in IDLE.
REQ-025 An edge and a watchdog expiry in the same cycle SHALL produce one step only.
REQ-026 timeout_flag SHALL clear only by reset.
REQ-027 An edge in IDLE SHALL have no effect.
REQ-028 Changes on req or req_x while in IDLE with an unchanged target SHALL cause no state change.

Reset
REQ-029 While rst_n is low, the block SHALL hold: x_out = IDLE_X, grant = 000, state = IDLE, settled = 1, div_q = 0, watchdog = 0, timeout_flag = 0.
REQ-030 Reset assertion mid-ramp SHALL immediately force the REQ-029 values with no completion of the ramp.
REQ-031 After rst_n deasserts, the block SHALL start its first evaluation on the next clk rising edge.

Verification
REQ-032 Scenario ramp up: N=4, IDLE_X=0; req=001, req_x0=3; divider pulses every 8 clk -> x_out steps 0,1,2,3, one step per div_clk_in rising edge; settled rises the cycle x_out=3; grant=001.
REQ-033 Scenario priority: req=110, req_x1=5, req_x2=1 -> grant=010 and target 5; then set req=111 with req_x0=2 -> grant=001 and the ramp redirects toward 2 with single steps only.
REQ-034 Scenario release: from x_out=4, req goes to 000 -> ramp down to 0 in 4 divider edges; grant=000 one cycle after release.
REQ-035 Scenario watchdog: TMO=10, div_clk_in held low, target 2 from 0 -> x_out=1 after 10 cycles in RAMP, x_out=2 after 10 more; timeout_flag=1 and stays high after the ramp completes.
REQ-036 Scenario reset mid-ramp: x_out=2 ramping toward 6, assert rst_n=0 between clk edges -> x_out=0, grant=000, settled=1 and timeout_flag=0 immediately; after release with req=000, x_out stays 0.
REQ-037 Scenario target returns: at x_out=3 ramping toward 7, the target changes to 3 -> state returns to IDLE the next cycle with no step taken.
